// File: rtl/echo_processor.sv
// -----------------------------------------------------------------------------
// echo_processor
//   Audio echo stage sitting between the ADC front end and the DAC/PWM back end.
//   Every accepted sample x is stored in a circular buffer and mixed with an
//   attenuated copy of the sample D positions earlier:
//     y = x + (x[n-D] >>> ATTEN_SHIFT), saturated to the 10-bit output range.
//   The delay D = (sw+1) * (DEPTH/16) samples is captured when a sample is
//   accepted. The buffer is a single-port, synchronous-read block RAM.
//
//   Build option:
//     ECHO_FEEDBACK_EN  defined -> the buffer stores the mixed output y, so the
//                       echo recirculates and decays.
//                       undefined (default) -> the buffer stores the input x,
//                       giving a single echo.
//
// Ports
//   sysclk      in   1   system clock, rising edge
//   rst_n       in   1   asynchronous reset, active low
//   data_in     in  10   ADC sample, offset binary (512 = midscale)
//   data_valid  in   1   one-cycle strobe qualifying data_in
//   sw          in   4   delay select
//   data_out    out 10   processed sample, offset binary, registered
//   out_valid   out  1   one-cycle strobe when data_out updates
//   overrun     out  1   sticky flag: a sample arrived while busy
// -----------------------------------------------------------------------------
module echo_processor #(
  parameter int DEPTH       = 8192,
  parameter int AW          = 13,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  input  logic [3:0] sw,
  output logic [9:0] data_out,
  output logic       out_valid,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e          state_q, state_d;
  logic [9:0]      x_q;
  logic [AW:0]     delay_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     fill_q;
  logic [9:0]      y_q;
  logic [9:0]      data_out_q;
  logic            out_valid_q;
  logic            overrun_q;

  logic [AW:0]     delay_sel;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [9:0]      ram_wdata;
  logic [9:0]      ram_rdata;
  logic [9:0]      y_calc;

  // D = (sw+1) * DEPTH/16; sw=15 yields exactly DEPTH, which needs the extra bit.
  assign delay_sel = ((AW+1)'(sw) + FILL_ONE) << (AW - 4);

  // Modulo-DEPTH wrap comes for free from the AW-bit subtraction; for D = DEPTH
  // the low bits are zero, so rd_addr == wr_ptr and the oldest sample is read.
  assign rd_addr  = wr_ptr_q - delay_q[AW-1:0];
  assign ram_we   = (state_q == WRITE);
  assign ram_addr = ram_we ? wr_ptr_q : rd_addr;

`ifdef ECHO_FEEDBACK_EN
  assign ram_wdata = y_q;
`else
  assign ram_wdata = x_q;
`endif

  // ---------------------------------------------------------------------------
  // Circular sample buffer: single port, one-cycle read latency.
  // ---------------------------------------------------------------------------
  logic [9:0] mem [DEPTH];

  // NOTE: the RAM array has no reset so it maps onto block RAM; stale contents
  // are harmless because the fill counter masks them until they are written.
  always_ff @(posedge sysclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Mixing datapath (valid in CALC, when ram_rdata holds the delayed sample).
  // ---------------------------------------------------------------------------
  logic [9:0]         echo_raw;
  logic signed [10:0] xs;
  logic signed [10:0] es;
  logic signed [10:0] eh;
  logic signed [11:0] sum;

  always_comb begin
    // Until D samples exist the echo is forced to midscale (zero signal).
    echo_raw = (fill_q < delay_q) ? 10'd512 : ram_rdata;
    xs       = $signed({1'b0, x_q})      - 11'sd512;
    es       = $signed({1'b0, echo_raw}) - 11'sd512;
    eh       = es >>> ATTEN_SHIFT;
    sum      = {xs[10], xs} + {eh[10], eh};
    if (sum > 12'sd511) begin
      y_calc = 10'd1023;
    end else if (sum < -12'sd512) begin
      y_calc = 10'd0;
    end else begin
      // Adding 512 to a 10-bit two's-complement value just flips the MSB.
      y_calc = {~sum[9], sum[8:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_valid) state_d = READ;
      READ:    state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      delay_q     <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      y_q         <= '0;
      data_out_q  <= 10'd512;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == WRITE);

      if (state_q == IDLE && data_valid) begin
        x_q     <= data_in;
        delay_q <= delay_sel;
      end

      // A strobe while busy is dropped; only the sticky flag records it.
      if (state_q != IDLE && data_valid) begin
        overrun_q <= 1'b1;
      end

      if (state_q == CALC) begin
        y_q <= y_calc;
      end

      if (state_q == WRITE) begin
        wr_ptr_q   <= wr_ptr_q + PTR_ONE;
        data_out_q <= y_q;
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + FILL_ONE;
        end
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
